// File: rtl/alu_issue_ctrl.sv
// Issue/collect controller for the 16-bit ALU: one op in flight, fixed 2-cycle unit latency.
// Optional op counter output Op_Count enabled by defining ALU_OP_COUNT_EN.
module alu_issue_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic [3:0]       ALU_FUN,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [1:0]       Unit_FUN,
    output logic             Arith_Enable,
    output logic             Logic_Enable,
    output logic             CMP_Enable,
    output logic             Shift_Enable,
    input  logic [WIDTH-1:0] Arith_OUT,
    input  logic [WIDTH-1:0] Logic_OUT,
    input  logic [WIDTH-1:0] CMP_OUT,
    input  logic [WIDTH-1:0] Shift_OUT,
    input  logic             Arith_Flag,
    input  logic             Logic_Flag,
    input  logic             CMP_Flag,
    input  logic             Shift_Flag,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             OUT_Valid,
    input  logic             Out_Ready,
`ifdef ALU_OP_COUNT_EN
    output logic             Flag_Err,
    output logic [15:0]      Op_Count
`else
    output logic             Flag_Err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       fun_q, fun_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic             out_valid_q, out_valid_d;
    logic             flag_err_q, flag_err_d;
    logic             accept;
    logic             handoff;
    logic [WIDTH-1:0] sel_result;
    logic             sel_flag;

    assign accept  = (state_q == IDLE) && In_Valid;
    assign handoff = (state_q == DONE) && Out_Ready;

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (In_Valid) state_d = ISSUE;
            ISSUE:   state_d = CAPT;
            CAPT:    state_d = DONE;
            DONE:    if (Out_Ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Enables are decoded from the state, so at most one is ever high and reset clears them at once.
    always_comb begin
        In_Ready     = (state_q == IDLE);
        Arith_Enable = (state_q == ISSUE) && (sel_q == 2'b00);
        Logic_Enable = (state_q == ISSUE) && (sel_q == 2'b01);
        CMP_Enable   = (state_q == ISSUE) && (sel_q == 2'b10);
        Shift_Enable = (state_q == ISSUE) && (sel_q == 2'b11);
    end

    always_comb begin
        sel_result = Arith_OUT;
        sel_flag   = Arith_Flag;
        case (sel_q)
            2'b00:   begin sel_result = Arith_OUT; sel_flag = Arith_Flag; end
            2'b01:   begin sel_result = Logic_OUT; sel_flag = Logic_Flag; end
            2'b10:   begin sel_result = CMP_OUT;   sel_flag = CMP_Flag;   end
            default: begin sel_result = Shift_OUT; sel_flag = Shift_Flag; end
        endcase
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        fun_d       = fun_q;
        sel_d       = sel_q;
        alu_out_d   = alu_out_q;
        out_valid_d = out_valid_q;
        flag_err_d  = flag_err_q;
        if (accept) begin
            a_d   = A_in;
            b_d   = B_in;
            fun_d = ALU_FUN[1:0];
            sel_d = ALU_FUN[3:2];
        end
        if (state_q == CAPT) begin
            alu_out_d   = sel_result;
            flag_err_d  = ~sel_flag;
            out_valid_d = 1'b1;
        end
        if (handoff) begin
            out_valid_d = 1'b0;
            flag_err_d  = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            sel_q       <= '0;
            alu_out_q   <= '0;
            out_valid_q <= 1'b0;
            flag_err_q  <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            fun_q       <= fun_d;
            sel_q       <= sel_d;
            alu_out_q   <= alu_out_d;
            out_valid_q <= out_valid_d;
            flag_err_q  <= flag_err_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign Unit_FUN  = fun_q;
    assign ALU_OUT   = alu_out_q;
    assign OUT_Valid = out_valid_q;
    assign Flag_Err  = flag_err_q;

`ifdef ALU_OP_COUNT_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (handoff) op_count_d = op_count_q + 16'd1;
    end

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign Op_Count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: emulated ALU units, transaction-level reference model, random plus directed stimulus.
module tb_alu_issue_ctrl;
    localparam int W = 16;

    logic         Clk = 1'b0;
    logic         RST = 1'b0;
    logic         In_Valid = 1'b0;
    logic         In_Ready;
    logic [W-1:0] A_in = '0, B_in = '0;
    logic [3:0]   ALU_FUN = '0;
    logic [W-1:0] A, B;
    logic [1:0]   Unit_FUN;
    logic         Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [W-1:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, Shift_OUT = '0;
    logic         Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, Shift_Flag = 1'b0;
    logic [W-1:0] ALU_OUT;
    logic         OUT_Valid;
    logic         Out_Ready = 1'b0;
    logic         Flag_Err;
    logic         req_err = 1'b0;
`ifdef ALU_OP_COUNT_EN
    logic [15:0]  Op_Count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue_ctrl #(.WIDTH(W)) dut (
        .Clk(Clk), .RST(RST), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .A_in(A_in), .B_in(B_in), .ALU_FUN(ALU_FUN),
        .A(A), .B(B), .Unit_FUN(Unit_FUN),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
        .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .Out_Ready(Out_Ready),
`ifdef ALU_OP_COUNT_EN
        .Flag_Err(Flag_Err), .Op_Count(Op_Count)
`else
        .Flag_Err(Flag_Err)
`endif
    );

    always #5 Clk = ~Clk;

    // What each ALU unit computes for a given 4-bit function code.
    function automatic logic [W-1:0] unit_fn(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (f)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = {8'h00, a[7:0]} * {8'h00, b[7:0]};
            4'b0011: r = a + b + 16'd1;
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = ~(a & b);
            4'b0111: r = a ^ b;
            4'b1000: r = (a == b) ? 16'd1 : 16'd0;
            4'b1001: r = (a > b) ? 16'd2 : 16'd0;
            4'b1010: r = (a < b) ? 16'd3 : 16'd0;
            4'b1011: r = 16'd0;
            4'b1100: r = a >> 1;
            4'b1101: r = a << 1;
            4'b1110: r = b >> 1;
            default: r = b << 1;
        endcase
        return r;
    endfunction

    // Reference model: transaction view of the request in flight.
    logic         m_busy = 1'b0;
    int           m_age = 0;
    logic [1:0]   m_sel = '0;
    logic         m_err = 1'b0;
    logic         m_cur_err = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [1:0]   m_fun = '0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_out = '0;
    int           m_count = 0;

    always @(posedge Clk or negedge RST) begin
        if (!RST) begin
            m_busy = 1'b0; m_age = 0; m_sel = '0; m_err = 1'b0;
            m_a = '0; m_b = '0; m_fun = '0; m_out = '0; m_count = 0;
        end else if (!m_busy) begin
            if (In_Valid) begin
                m_busy = 1'b1; m_age = 1;
                m_a = A_in; m_b = B_in; m_fun = ALU_FUN[1:0]; m_sel = ALU_FUN[3:2];
                m_err = req_err; m_cur_err = req_err;
                m_result = unit_fn(ALU_FUN, A_in, B_in);
            end
        end else if (m_age < 3) begin
            m_age = m_age + 1;
            if (m_age == 3) m_out = m_result;
        end else if (Out_Ready) begin
            m_busy = 1'b0; m_age = 0; m_err = 1'b0;
            m_count = m_count + 1;
        end
    end

    // Emulated units register on their enable; flag low when an error is injected.
    always @(posedge Clk) begin
        if (Arith_Enable) begin Arith_OUT <= unit_fn({2'b00, Unit_FUN}, A, B); Arith_Flag <= !m_cur_err; end
        if (Logic_Enable) begin Logic_OUT <= unit_fn({2'b01, Unit_FUN}, A, B); Logic_Flag <= !m_cur_err; end
        if (CMP_Enable)   begin CMP_OUT   <= unit_fn({2'b10, Unit_FUN}, A, B); CMP_Flag   <= !m_cur_err; end
        if (Shift_Enable) begin Shift_OUT <= unit_fn({2'b11, Unit_FUN}, A, B); Shift_Flag <= !m_cur_err; end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        logic [3:0] en_exp;
        en_exp = (m_age == 1) ? (4'b0001 << m_sel) : 4'b0000;
        chk("in_ready",  {31'd0, In_Ready},  {31'd0, !m_busy});
        chk("enables",   {28'd0, Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, {28'd0, en_exp});
        chk("out_valid", {31'd0, OUT_Valid}, {31'd0, m_age == 3});
        chk("flag_err",  {31'd0, Flag_Err},  {31'd0, (m_age == 3) && m_err});
        chk("alu_out",   {16'd0, ALU_OUT},   {16'd0, m_out});
        chk("op_a",      {16'd0, A},         {16'd0, m_a});
        chk("op_b",      {16'd0, B},         {16'd0, m_b});
        chk("unit_fun",  {30'd0, Unit_FUN},  {30'd0, m_fun});
`ifdef ALU_OP_COUNT_EN
        chk("op_count",  {16'd0, Op_Count},  {16'd0, m_count[15:0]});
`endif
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    // Directed op with literal expectations; holds Out_Ready low for 'hold' cycles in DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f,
                          input logic err, input int hold, input logic [W-1:0] exp_out);
        step();
        In_Valid = 1'b1; A_in = a; B_in = b; ALU_FUN = f; req_err = err; Out_Ready = 1'b0;
        step();
        In_Valid = 1'b0;
        @(negedge Clk);
        chk("lit_enable_issue", {28'd0, Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable},
            {28'd0, 4'b0001 << f[3:2]});
        chk("lit_unit_fun", {30'd0, Unit_FUN}, {30'd0, f[1:0]});
        step();
        @(negedge Clk);
        chk("lit_enable_capt", {28'd0, Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, 32'd0);
        chk("lit_valid_capt", {31'd0, OUT_Valid}, 32'd0);
        step();
        @(negedge Clk);
        chk("lit_out_valid", {31'd0, OUT_Valid}, 32'd1);
        chk("lit_alu_out", {16'd0, ALU_OUT}, {16'd0, exp_out});
        chk("lit_flag_err", {31'd0, Flag_Err}, {31'd0, err});
        In_Valid = 1'b1; A_in = 16'hDEAD; B_in = 16'hBEEF; ALU_FUN = 4'b0000;
        for (int i = 0; i < hold; i++) begin
            step();
            @(negedge Clk);
            chk("lit_hold_valid", {31'd0, OUT_Valid}, 32'd1);
            chk("lit_hold_ready", {31'd0, In_Ready}, 32'd0);
            chk("lit_hold_out", {16'd0, ALU_OUT}, {16'd0, exp_out});
        end
        step();
        Out_Ready = 1'b1; In_Valid = 1'b0;
        step();
        Out_Ready = 1'b0;
        @(negedge Clk);
        chk("lit_back_idle", {31'd0, In_Ready}, 32'd1);
        chk("lit_valid_clear", {31'd0, OUT_Valid}, 32'd0);
        chk("lit_flag_clear", {31'd0, Flag_Err}, 32'd0);
        chk("lit_out_kept", {16'd0, ALU_OUT}, {16'd0, exp_out});
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);
        chk("rst_out_valid", {31'd0, OUT_Valid}, 32'd0);
        chk("rst_alu_out", {16'd0, ALU_OUT}, 32'd0);
        step();
        RST = 1'b1;

        run_op(16'h8001, 16'h0003, 4'b1100, 1'b0, 5, 16'h4000);
        run_op(16'h8001, 16'h0003, 4'b1111, 1'b0, 0, 16'h0006);
        run_op(16'h8001, 16'h0003, 4'b1101, 1'b1, 2, 16'h0002);
        run_op(16'h1234, 16'h0F0F, 4'b0111, 1'b0, 1, 16'h1D3B);

        // Reset asserted while an op sits in ISSUE.
        step();
        In_Valid = 1'b1; A_in = 16'h5555; B_in = 16'h0001; ALU_FUN = 4'b0001;
        step();
        In_Valid = 1'b0;
        @(negedge Clk);
        #3;
        RST = 1'b0;
        #1;
        chk("rst_mid_enables", {28'd0, Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, 32'd0);
        chk("rst_mid_valid", {31'd0, OUT_Valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, In_Ready}, 32'd1);
        step();
        RST = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            step();
            In_Valid  = ($urandom_range(0, 3) != 0);
            A_in      = W'($urandom);
            B_in      = W'($urandom);
            ALU_FUN   = 4'($urandom);
            req_err   = ($urandom_range(0, 7) == 0);
            Out_Ready = ($urandom_range(0, 9) < 7);
        end
        step();
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        repeat (6) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
